wb_macro_mux: RTL and testbench

- Wishbone fabric stage between the management-core Wishbone master and the N_MACROS user macro tiles of the array. Each macro tile is a plain Wishbone slave.
- Decodes the host address and forwards a single transaction to exactly one macro.
- Returns that macro's ack and read data to the host.
- Guarantees termination: address misses and silent macros are answered with an error word after a bounded time.

---
 rtl/wb_macro_mux.sv | 183 ++++++++++++++++++
 tb/tb_wb_macro_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_macro_mux.sv
// rtl/wb_macro_mux.sv - Wishbone host-to-macro fabric mux with bounded response time.
// Optional status register (timeout statistics) enabled by WB_MUX_STATUS_EN.
module wb_macro_mux #(
    parameter int          N_MACROS = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          SEL_LSB  = 16,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [N_MACROS-1:0]    m_cyc_o,
    output logic [N_MACROS-1:0]    m_stb_o,
    output logic                   m_we_o,
    output logic [3:0]             m_sel_o,
    output logic [31:0]            m_dat_o,
    output logic [31:0]            m_adr_o,
    input  logic [N_MACROS-1:0]    m_ack_i,
    input  logic [32*N_MACROS-1:0] m_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [1:0]          idx_q;
    logic                ack_q;
    logic [31:0]         rdat_q;
    logic [N_MACROS-1:0] strb_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [31:0]         wdat_q;
    logic [31:0]         adr_q;

    logic                req;
    logic                region_hit;
    logic                macro_hit;
    logic [1:0]          req_idx;
    logic [N_MACROS-1:0] req_onehot;
    logic                sel_ack;
    logic [31:0]         sel_dat;

    assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign req_idx    = wbs_adr_i[SEL_LSB+1:SEL_LSB];
    assign region_hit = (wbs_adr_i[31:24] == BASE_ADR[31:24]);
    assign macro_hit  = region_hit && ({30'd0, req_idx} < 32'(N_MACROS));

    // Only the selected port's ack/data matter; strays on other ports never reach the FSM.
    always_comb begin
        sel_ack    = 1'b0;
        sel_dat    = '0;
        req_onehot = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            if (idx_q == 2'(k)) begin
                sel_ack = m_ack_i[k];
                sel_dat = m_dat_i[32*k +: 32];
            end
            if (req_idx == 2'(k)) begin
                req_onehot[k] = 1'b1;
            end
        end
    end

`ifdef WB_MUX_STATUS_EN
    logic [15:0] to_cnt_q;
    logic        to_valid_q;
    logic [1:0]  to_idx_q;
    logic        status_hit;
    logic [31:0] status_word;

    assign status_hit  = region_hit && (wbs_adr_i[23:20] == 4'hF);
    assign status_word = {to_cnt_q, 12'h0, to_valid_q, 1'b0, to_idx_q};
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            adr_q   <= '0;
`ifdef WB_MUX_STATUS_EN
            to_cnt_q   <= '0;
            to_valid_q <= 1'b0;
            to_idx_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
`ifdef WB_MUX_STATUS_EN
                        if (status_hit) begin
                            rdat_q  <= status_word;
                            ack_q   <= 1'b1;
                            state_q <= S_RESP;
                            if (wbs_we_i) begin
                                to_cnt_q   <= '0;
                                to_valid_q <= 1'b0;
                            end
                        end else
`endif
                        if (macro_hit) begin
                            idx_q   <= req_idx;
                            we_q    <= wbs_we_i;
                            sel_q   <= wbs_sel_i;
                            wdat_q  <= wbs_dat_i;
                            adr_q   <= wbs_adr_i;
                            strb_q  <= req_onehot;
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            rdat_q  <= ERR_DATA;
                            ack_q   <= 1'b1;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    // Host abandoning the cycle takes precedence: it is no longer listening.
                    if (!wbs_cyc_i) begin
                        strb_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (sel_ack) begin
                        rdat_q  <= sel_dat;
                        strb_q  <= '0;
                        ack_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        rdat_q  <= ERR_DATA;
                        strb_q  <= '0;
                        ack_q   <= 1'b1;
                        state_q <= S_RESP;
`ifdef WB_MUX_STATUS_EN
                        to_valid_q <= 1'b1;
                        to_idx_q   <= idx_q;
                        if (to_cnt_q != 16'hFFFF) begin
                            to_cnt_q <= to_cnt_q + 16'd1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign m_cyc_o   = strb_q;
    assign m_stb_o   = strb_q;
    assign m_we_o    = we_q;
    assign m_sel_o   = sel_q;
    assign m_dat_o   = wdat_q;
    assign m_adr_o   = adr_q;

endmodule

// File: tb/tb_wb_macro_mux.sv
// tb/tb_wb_macro_mux.sv - scoreboard bench for wb_macro_mux (TIMEOUT=8).
module tb_wb_macro_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stb = 1'b0;
    logic         cyc = 1'b0;
    logic         we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  hdat = 32'h0;
    logic [31:0]  adr = 32'h0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [3:0]   m_cyc_o;
    logic [3:0]   m_stb_o;
    logic         m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_dat_o;
    logic [31:0]  m_adr_o;
    logic [3:0]   m_ack = 4'h0;
    logic [127:0] m_dat = {32'h3333_3333, 32'd4, 32'h1111_1111, 32'h0000_00A0};

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    typedef struct {
        string       name;
        logic [31:0] dat;
        int          cycle;
    } ack_exp_t;

    typedef struct {
        string       name;
        logic [3:0]  onehot;
        int          cycles;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } stb_exp_t;

    ack_exp_t ack_q[$];
    stb_exp_t stb_q[$];

    wb_macro_mux #(.TIMEOUT(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_dat_i(hdat),
        .wbs_adr_i(adr),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .m_cyc_o  (m_cyc_o),
        .m_stb_o  (m_stb_o),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_dat_o  (m_dat_o),
        .m_adr_o  (m_adr_o),
        .m_ack_i  (m_ack),
        .m_dat_i  (m_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n = cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Host-side monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack data %h expected no ack (cycle %0d)", wbs_dat_o, cyc_n);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                check({e.name, "_rdata"}, wbs_dat_o, e.dat);
                check({e.name, "_ack_cycle"}, 32'(cyc_n), 32'(e.cycle));
            end
        end
    end

    // Macro-side monitor: records each strobe burst and compares it when it ends.
    logic [3:0]  s_hot;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    int          s_len = 0;
    bit          s_cyc_ok;
    always @(negedge clk) begin
        if (m_stb_o != 4'h0) begin
            if (s_len == 0) begin
                s_hot = m_stb_o; s_adr = m_adr_o; s_dat = m_dat_o;
                s_sel = m_sel_o; s_we = m_we_o; s_cyc_ok = 1'b1;
            end else if (m_stb_o != s_hot || m_adr_o != s_adr || m_dat_o != s_dat) begin
                s_cyc_ok = 1'b0;
            end
            if (m_cyc_o != m_stb_o) s_cyc_ok = 1'b0;
            s_len++;
        end else if (s_len != 0) begin
            if (stb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got strobe %b for %0d cycles expected none", s_hot, s_len);
            end else begin
                stb_exp_t e;
                e = stb_q.pop_front();
                check({e.name, "_stb_onehot"}, 32'(s_hot), 32'(e.onehot));
                check({e.name, "_stb_cycles"}, 32'(s_len), 32'(e.cycles));
                check({e.name, "_m_adr"}, s_adr, e.adr);
                check({e.name, "_m_dat"}, s_dat, e.dat);
                check({e.name, "_m_sel"}, 32'(s_sel), 32'(e.sel));
                check({e.name, "_m_we"}, 32'(s_we), 32'(e.we));
                check({e.name, "_stable_cyc"}, 32'(s_cyc_ok), 32'd1);
            end
            s_len = 0;
        end
    end

    // Drives a request in the current cycle and queues its expected effects.
    task automatic issue(input string name, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit exp_ack, input int lat, input logic [31:0] rdata,
                         input logic [3:0] hot, input int stb_cycles);
        ack_exp_t ae;
        stb_exp_t se;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; hdat = d; sel = s;
        if (exp_ack) begin
            ae.name = name; ae.dat = rdata; ae.cycle = cyc_n + lat;
            ack_q.push_back(ae);
        end
        if (hot != 4'h0) begin
            se.name = name; se.onehot = hot; se.cycles = stb_cycles;
            se.adr = a; se.dat = d; se.sel = s; se.we = w;
            stb_q.push_back(se);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (!wbs_ack_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!wbs_ack_o) begin
            checks++;
            failures++;
            $display("FAIL ack_wait: got no ack in 40 cycles expected ack");
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, 32'(wbs_ack_o), 32'd0);
        check({tag, "_rdata"}, wbs_dat_o, 32'd0);
        check({tag, "_cyc"}, 32'(m_cyc_o), 32'd0);
        check({tag, "_stb"}, 32'(m_stb_o), 32'd0);
        check({tag, "_we"}, 32'(m_we_o), 32'd0);
        check({tag, "_sel"}, 32'(m_sel_o), 32'd0);
        check({tag, "_mdat"}, m_dat_o, 32'd0);
        check({tag, "_madr"}, m_adr_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        m_ack = 4'b0010;
        issue("wr_m1", 32'h3001_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 1, 2, 32'h1111_1111, 4'b0010, 1);
        wait_ack();
        go_idle();

        m_ack = 4'b0100;
        issue("rd_m2", 32'h3002_0000, 1'b0, 32'h0, 4'hF, 1, 2, 32'd4, 4'b0100, 1);
        wait_ack();
        go_idle();

        m_ack = 4'b0001;
        issue("timeout_m3", 32'h3003_0000, 1'b0, 32'h0, 4'hF, 1, 9, 32'hDEAD_BEEF, 4'b1000, 8);
        wait_ack();
        go_idle();

        m_ack = 4'b0100;
        issue("miss", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1, 1, 32'hDEAD_BEEF, 4'b0000, 0);
        wait_ack();
        issue("b2b_m2", 32'h3002_0000, 1'b0, 32'h0, 4'h3, 1, 2, 32'd4, 4'b0100, 1);
        wait_ack();
        go_idle();

        m_ack = 4'b0000;
        issue("abort", 32'h3003_0004, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 4'b1000, 3);
        repeat (3) @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0;
        repeat (4) @(posedge clk);

        issue("rst_mid", 32'h3002_0010, 1'b1, 32'hCAFE_0001, 4'hF, 0, 0, 32'h0, 4'b0100, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");

        m_ack = 4'b0001;
        issue("wr_m0", 32'h3000_0008, 1'b1, 32'h0BAD_F00D, 4'b0011, 1, 2, 32'h0000_00A0, 4'b0001, 1);
        wait_ack();
        go_idle();

`ifdef WB_MUX_STATUS_EN
        m_ack = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            issue("st_to", 32'h3003_0000, 1'b0, 32'h0, 4'hF, 1, 9, 32'hDEAD_BEEF, 4'b1000, 8);
            wait_ack();
            go_idle();
        end
        issue("st_rd1", 32'h30F0_0000, 1'b0, 32'h0, 4'hF, 1, 1, 32'h0002_000B, 4'b0000, 0);
        wait_ack();
        go_idle();
        issue("st_wr", 32'h30F0_0000, 1'b1, 32'h0, 4'hF, 1, 1, 32'h0002_000B, 4'b0000, 0);
        wait_ack();
        go_idle();
        issue("st_rd2", 32'h30F0_0000, 1'b0, 32'h0, 4'hF, 1, 1, 32'h0000_0003, 4'b0000, 0);
        wait_ack();
        go_idle();
`endif

        repeat (6) @(negedge clk);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("stb_queue_drained", 32'(stb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
